// File: rtl/spdif_pkg.sv
// Shared constants for the S/PDIF transmit path: preamble codes, block length,
// and bit positions inside the 32-bit IEC 60958 subframe word.
package spdif_pkg;

    localparam logic [1:0] PRE_B = 2'b00;   // block start (left, frame 0)
    localparam logic [1:0] PRE_M = 2'b01;   // left, frames 1..191
    localparam logic [1:0] PRE_W = 2'b10;   // right

    localparam int FRAMES_PER_BLOCK = 192;

    localparam int AUDIO_MSB = 27;
    localparam int BIT_V     = 28;
    localparam int BIT_U     = 29;
    localparam int BIT_C     = 30;
    localparam int BIT_P     = 31;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

endpackage

// File: rtl/spdif_cs_bit.sv
// Channel-status bit select: only bits 0..31 of the block are programmable,
// the remaining 160 bits of the block are always 0.
module spdif_cs_bit #(
    parameter logic [31:0] CS_LO = 32'h0000_0000
) (
    input  logic [7:0] frame_idx_i,
    output logic       cs_o
);

    // Frame index selects a CS_LO bit for the first 32 frames, 0 afterwards
    always_comb begin
        cs_o = 1'b0;
        if (frame_idx_i < 8'd32) cs_o = CS_LO[frame_idx_i[4:0]];
    end

endmodule

// File: rtl/spdif_subframe_builder.sv
// Builds IEC 60958 subframes from buffered stereo PCM pairs for the
// biphase-mark encoder. One-pair holding register, left/right channel
// pointer, 192-frame block counter, sticky underrun flag.
module spdif_subframe_builder
    import spdif_pkg::*;
#(
    parameter int          SAMPLE_W = 24,
    parameter logic [31:0] CS_LO    = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                sf_req,
    output logic                sf_ack,
    output logic [31:0]         sf_data,
    output logic [1:0]          sf_pre,
    output logic [7:0]          frame_idx,
    output logic                underrun
);

    chan_e               chan_q, chan_d;
    logic                full_q;
    logic [SAMPLE_W-1:0] l_q, r_q;
    logic                live_q, live_d;
    logic [7:0]          frame_q;
    logic                rel_q;      // right subframe with live pair just acked: free the pair
    logic                adv_q;      // right subframe just acked: advance frame
    logic                ack_q;
    logic [31:0]         data_q;
    logic [1:0]          pre_q;
    logic                underrun_q;

    logic [7:0]          frame_nxt, cur_frame;
    logic                avail, use_live, cs_bit;
    logic [SAMPLE_W-1:0] sample;
    logic [23:0]         aud;
    logic [31:0]         word_d;
    logic [1:0]          pre_d;

    // The pair release and frame advance land one cycle after the right ack;
    // a left request in that same cycle must already see their effect.
    assign frame_nxt = (frame_q == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_q + 8'd1;
    assign cur_frame = adv_q ? frame_nxt : frame_q;
    assign avail     = full_q && !rel_q;

    spdif_cs_bit #(.CS_LO(CS_LO)) u_cs (
        .frame_idx_i (cur_frame),
        .cs_o        (cs_bit)
    );

    // Channel pointer and live flag next state, plus the subframe word for a request
    always_comb begin
        chan_d   = chan_q;
        live_d   = live_q;
        use_live = live_q;
        sample   = r_q;
        pre_d    = PRE_W;
        if (chan_q == CH_LEFT) begin
            use_live = avail;
            sample   = l_q;
            pre_d    = (cur_frame == 8'd0) ? PRE_B : PRE_M;
        end
        if (sf_req) begin
            live_d = use_live;
            chan_d = (chan_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end

        aud = '0;
        aud[23 -: SAMPLE_W] = sample;   // left-justified, LSBs below SAMPLE_W stay 0

        word_d = '0;
        word_d[AUDIO_MSB -: 24] = use_live ? aud : 24'd0;
        word_d[BIT_V]           = !use_live;
        word_d[BIT_U]           = 1'b0;
        word_d[BIT_C]           = cs_bit;
        word_d[BIT_P]           = ^word_d[BIT_C:4];
    end

    // Channel pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) chan_q <= CH_LEFT;
        else        chan_q <= chan_d;
    end

    // Holding register, frame counter, subframe output registers and underrun flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q     <= 1'b0;
            l_q        <= '0;
            r_q        <= '0;
            live_q     <= 1'b0;
            frame_q    <= 8'd0;
            rel_q      <= 1'b0;
            adv_q      <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= 32'd0;
            pre_q      <= PRE_B;
            underrun_q <= 1'b0;
        end else begin
            if (s_valid && !full_q) begin
                full_q <= 1'b1;
                l_q    <= s_left;
                r_q    <= s_right;
            end else if (rel_q) begin
                full_q <= 1'b0;
            end
            if (adv_q) frame_q <= frame_nxt;
            live_q <= live_d;
            rel_q  <= sf_req && (chan_q == CH_RIGHT) && live_q;
            adv_q  <= sf_req && (chan_q == CH_RIGHT);
            ack_q  <= sf_req;
            if (sf_req) begin
                data_q <= word_d;
                pre_q  <= pre_d;
                if (!use_live) underrun_q <= 1'b1;
            end
        end
    end

    assign s_ready   = !full_q;
    assign sf_ack    = ack_q;
    assign sf_data   = data_q;
    assign sf_pre    = pre_q;
    assign frame_idx = frame_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_spdif_subframe_builder.sv
// Directed bench for spdif_subframe_builder: 24-bit instance with CS_LO
// programmed, plus a 16-bit instance for the narrow-sample placement.
module tb_spdif_subframe_builder;

    localparam logic [31:0] CS = 32'h0200_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_left = '0, s_right = '0;
    logic        sf_req = 1'b0;
    logic        sf_ack;
    logic [31:0] sf_data;
    logic [1:0]  sf_pre;
    logic [7:0]  frame_idx;
    logic        underrun;

    logic        v16 = 1'b0, req16 = 1'b0;
    logic [15:0] l16 = '0, r16 = '0;
    logic        rdy16, ack16, und16;
    logic [31:0] dat16;
    logic [1:0]  pre16;
    logic [7:0]  fi16;

    int n_cmp = 0;
    int n_err = 0;

    logic        ack_a [4];
    logic [31:0] dat_a [4];
    logic [1:0]  pre_a [4];

    always #5 clk = ~clk;

    spdif_subframe_builder #(.SAMPLE_W(24), .CS_LO(CS)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .sf_req(sf_req), .sf_ack(sf_ack),
        .sf_data(sf_data), .sf_pre(sf_pre), .frame_idx(frame_idx), .underrun(underrun)
    );

    spdif_subframe_builder #(.SAMPLE_W(16), .CS_LO(32'h0)) dut16 (
        .clk(clk), .rst_n(rst_n), .s_valid(v16), .s_ready(rdy16),
        .s_left(l16), .s_right(r16), .sf_req(req16), .sf_ack(ack16),
        .sf_data(dat16), .sf_pre(pre16), .frame_idx(fi16), .underrun(und16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [23:0] a, input logic v, input int f);
        logic [31:0] w;
        w = {1'b0, (f < 32) ? CS[f % 32] : 1'b0, 1'b0, v, a, 4'h0};
        w[31] = ^w[30:4];
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic load(input logic [23:0] l, input logic [23:0] r);
        int n = 0;
        while (!s_ready && n < 20) begin @(negedge clk); n++; end
        chk("load_ready_timeout", {31'd0, s_ready}, 32'd1);
        s_left = l; s_right = r; s_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic reqs(input int n);
        @(negedge clk); sf_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            ack_a[i] = sf_ack; dat_a[i] = sf_data; pre_a[i] = sf_pre;
            if (i == n - 1) sf_req = 1'b0;
        end
    endtask

    task automatic frame_chk(input int f, input logic [23:0] l, input logic [23:0] r);
        int fi = f % 192;
        load(l, r);
        chk($sformatf("fidx_%0d", f), {24'd0, frame_idx}, fi);
        reqs(2);
        chk($sformatf("ackL_%0d", f), {31'd0, ack_a[0]}, 32'd1);
        chk($sformatf("preL_%0d", f), {30'd0, pre_a[0]}, (fi == 0) ? 32'd0 : 32'd1);
        chk($sformatf("datL_%0d", f), dat_a[0], model(l, 1'b0, fi));
        chk($sformatf("ackR_%0d", f), {31'd0, ack_a[1]}, 32'd1);
        chk($sformatf("preR_%0d", f), {30'd0, pre_a[1]}, 32'd2);
        chk($sformatf("datR_%0d", f), dat_a[1], model(r, 1'b0, fi));
    endtask

    initial begin
        // Reset state
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        chk("rst_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_ack", {31'd0, sf_ack}, 32'd0);
        chk("rst_data", sf_data, 32'd0);
        chk("rst_pre", {30'd0, sf_pre}, 32'd0);
        chk("rst_fidx", {24'd0, frame_idx}, 32'd0);
        chk("rst_und", {31'd0, underrun}, 32'd0);

        // 1: request with nothing buffered
        reqs(1);
        chk("t1_ack", {31'd0, ack_a[0]}, 32'd1);
        chk("t1_pre", {30'd0, pre_a[0]}, 32'd0);
        chk("t1_data", dat_a[0], 32'h9000_0000);
        chk("t1_und", {31'd0, underrun}, 32'd1);
        @(negedge clk);
        chk("t1_ack_pulse", {31'd0, sf_ack}, 32'd0);
        chk("t1_hold", sf_data, 32'h9000_0000);

        // 2: one pair, then three back-to-back requests (third finds the pair consumed)
        do_reset();
        load(24'h123456, 24'hABCDEF);
        chk("t2_full", {31'd0, s_ready}, 32'd0);
        reqs(3);
        chk("t2_L", dat_a[0], 32'h8123_4560);
        chk("t2_Lpre", {30'd0, pre_a[0]}, 32'd0);
        chk("t2_R", dat_a[1], 32'h8ABC_DEF0);
        chk("t2_Rpre", {30'd0, pre_a[1]}, 32'd2);
        chk("t2_ack3", {31'd0, ack_a[2]}, 32'd1);
        chk("t2_L2", dat_a[2], 32'h9000_0000);
        chk("t2_L2pre", {30'd0, pre_a[2]}, 32'd1);
        chk("t2_ready", {31'd0, s_ready}, 32'd1);

        // 3/4: full block plus one frame, wrap and channel-status bits
        do_reset();
        for (int f = 0; f < 193; f++) begin
            frame_chk(f, 24'(f * 24'h010203) ^ 24'h5A5A5A, 24'(f * 24'h030507) ^ 24'hA5A5A5);
            if (f == 2 || f == 25)
                chk($sformatf("t4_C1_%0d", f), {31'd0, dat_a[0][30] & dat_a[1][30]}, 32'd1);
            if (f == 3 || f == 40)
                chk($sformatf("t4_C0_%0d", f), {31'd0, dat_a[0][30] | dat_a[1][30]}, 32'd0);
            if (f == 191) begin
                @(negedge clk);
                chk("t3_wrap", {24'd0, frame_idx}, 32'd0);
            end
        end

        // 5: underrun on left, pair arrives before right, pair deferred
        @(negedge clk); @(negedge clk);
        chk("t5_fidx", {24'd0, frame_idx}, 32'd1);
        reqs(1);
        chk("t5_L", dat_a[0], 32'h9000_0000);
        chk("t5_Lpre", {30'd0, pre_a[0]}, 32'd1);
        chk("t5_und", {31'd0, underrun}, 32'd1);
        load(24'h000001, 24'h000003);
        chk("t5_full", {31'd0, s_ready}, 32'd0);
        reqs(1);
        chk("t5_R", dat_a[0], 32'h9000_0000);
        chk("t5_Rpre", {30'd0, pre_a[0]}, 32'd2);
        @(negedge clk);
        chk("t5_still_full", {31'd0, s_ready}, 32'd0);
        reqs(2);
        chk("t5_L_next", dat_a[0], 32'h4000_0010);
        chk("t5_R_next", dat_a[1], 32'hC000_0030);

        // 6: reset mid-block at frame 100 (request during reset ignored)
        for (int f = 3; f < 100; f++)
            frame_chk(f, 24'(f * 24'h000731), 24'(~(f * 24'h001357)));
        load(24'h0F0F0F, 24'hF0F0F0);
        reqs(1);
        chk("t6_fidx", {24'd0, frame_idx}, 32'd100);
        chk("t6_Lpre", {30'd0, pre_a[0]}, 32'd1);
        @(negedge clk); rst_n = 1'b0; sf_req = 1'b1;
        @(negedge clk); rst_n = 1'b1; sf_req = 1'b0;
        chk("t6_ack", {31'd0, sf_ack}, 32'd0);
        chk("t6_ready", {31'd0, s_ready}, 32'd1);
        chk("t6_fidx0", {24'd0, frame_idx}, 32'd0);
        chk("t6_und", {31'd0, underrun}, 32'd0);
        @(negedge clk);
        chk("t6_noack", {31'd0, sf_ack}, 32'd0);
        load(24'h000001, 24'h000003);
        reqs(1);
        chk("t6_pre", {30'd0, pre_a[0]}, 32'd0);
        chk("t6_dat", dat_a[0], 32'h8000_0010);
        chk("t6_und2", {31'd0, underrun}, 32'd0);

        // 7: 16-bit samples are left-justified
        @(negedge clk); l16 = 16'h8001; r16 = 16'h0001; v16 = 1'b1;
        @(negedge clk); v16 = 1'b0;
        chk("t7_full", {31'd0, rdy16}, 32'd0);
        req16 = 1'b1;
        @(negedge clk);
        chk("t7_ackL", {31'd0, ack16}, 32'd1);
        chk("t7_L", dat16, 32'h0800_1000);
        chk("t7_Lpre", {30'd0, pre16}, 32'd0);
        @(negedge clk); req16 = 1'b0;
        chk("t7_R", dat16, 32'h8000_1000);
        chk("t7_Rpre", {30'd0, pre16}, 32'd2);
        chk("t7_und", {31'd0, und16}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
